// File: rtl/hmac_bus_master.sv
// Register-bus initiator that runs one HMAC job: loads key and message into the
// peripheral, triggers the hash, polls for completion and reads the digest back.
module hmac_bus_master #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    POLL_MAX   = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [255:0]          key_i,
    input  logic [511:0]          message_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [255:0]          hash_o,
    output logic                  bus_valid_o,
    output logic                  bus_write_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic                  bus_ready_i,
    input  logic                  bus_error_i
);

    localparam int PW = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_POLL_RDY, S_WR_KEY, S_WR_MSG, S_WR_CLR,
        S_WR_GO, S_SETTLE, S_POLL_VLD, S_RD_HASH, S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [4:0]     cnt_q;
    logic [PW-1:0]  poll_q;
    logic           gap_q;
    logic           err_q;
    logic [255:0]   key_q;
    logic [511:0]   msg_q;
    logic [255:0]   hash_q;

    logic        req, wr, xfer;
    logic        cnt_clr, cnt_inc, poll_inc, capture, fail, hash_we;
    logic [5:0]  word;
    logic [31:0] wdata;

    // A request is withheld for the cycle after each completion (gap_q).
    assign xfer = req && bus_ready_i;

    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        wr       = 1'b0;
        word     = 6'd0;
        wdata    = 32'd0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        poll_inc = 1'b0;
        capture  = 1'b0;
        fail     = 1'b0;
        hash_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    capture = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = S_POLL_RDY;
                end
            end
            S_POLL_RDY, S_POLL_VLD: begin
                req  = !gap_q;
                word = (state_q == S_POLL_RDY) ? 6'd0 : 6'd17;
                if (xfer) begin
                    if (bus_rdata_i[0]) begin
                        cnt_clr = 1'b1;
                        state_d = (state_q == S_POLL_RDY) ? S_WR_KEY : S_RD_HASH;
                    end else if (poll_q == PW'(POLL_MAX - 1)) begin
                        fail    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        poll_inc = 1'b1;
                    end
                end
            end
            S_WR_KEY: begin
                req   = !gap_q;
                wr    = 1'b1;
                word  = 6'd26 + {1'b0, cnt_q};
                wdata = key_q[{cnt_q[2:0], 5'd0} +: 32];
                if (xfer) begin
                    if (cnt_q == 5'd7) begin
                        cnt_clr = 1'b1;
                        state_d = S_WR_MSG;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_WR_MSG: begin
                req   = !gap_q;
                wr    = 1'b1;
                word  = 6'd1 + {1'b0, cnt_q};
                wdata = msg_q[{cnt_q[3:0], 5'd0} +: 32];
                if (xfer) begin
                    if (cnt_q == 5'd15) begin
                        cnt_clr = 1'b1;
                        state_d = S_WR_CLR;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_WR_CLR: begin
                req = !gap_q;
                wr  = 1'b1;
                if (xfer) state_d = S_WR_GO;
            end
            S_WR_GO: begin
                req   = !gap_q;
                wr    = 1'b1;
                wdata = 32'd1;
                if (xfer) begin
                    cnt_clr = 1'b1;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Two quiet cycles let the peripheral drop a stale hashValid.
                if (cnt_q == 5'd1) begin
                    cnt_clr = 1'b1;
                    state_d = S_POLL_VLD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_RD_HASH: begin
                req  = !gap_q;
                word = 6'd18 + {1'b0, cnt_q};
                if (xfer) begin
                    hash_we = 1'b1;
                    if (cnt_q == 5'd7) state_d = S_DONE;
                    else               cnt_inc = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (xfer && bus_error_i) begin
            fail    = 1'b1;
            hash_we = 1'b0;
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            poll_q <= '0;
            gap_q  <= 1'b0;
            err_q  <= 1'b0;
            key_q  <= '0;
            msg_q  <= '0;
            hash_q <= '0;
        end else begin
            gap_q <= xfer;
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + 5'd1;
            if (cnt_clr)       poll_q <= '0;
            else if (poll_inc) poll_q <= poll_q + 1'b1;
            if (capture) begin
                key_q  <= key_i;
                msg_q  <= message_i;
                err_q  <= 1'b0;
                hash_q <= '0;
            end
            if (fail)    err_q <= 1'b1;
            if (hash_we) hash_q[{cnt_q[2:0], 5'd0} +: 32] <= bus_rdata_i[31:0];
        end
    end

    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;
    assign hash_o      = hash_q;
    assign bus_valid_o = req;
    assign bus_write_o = req && wr;
    assign bus_addr_o  = req ? BASE_ADDR + ADDR_WIDTH'({word, 2'b00}) : '0;
    assign bus_wdata_o = req ? DATA_WIDTH'(wdata) : '0;

endmodule
